// File: rtl/feature_concat_pkg.sv
// Shared types and constants for the U-Net decoder channel-concatenation stage.
package feature_concat_pkg;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic {SEL1, SEL2} phase_t;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Words per frame on one stream.
  function automatic int unsigned frame_words(input int unsigned h, input int unsigned w,
                                              input int unsigned c);
    return h * w * c;
  endfunction

endpackage

// File: rtl/feature_concat_sync_fifo.sv
// Synchronous FIFO with registered read data, registered full/empty and a synchronous flush.
module sync_fifo
  import feature_concat_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned AW = (clog2(FIFO_DEPTH) > 0) ? clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  full_q, empty_q;
  logic                  wr_do, rd_do;

  assign wr_do = wr_en_i && !full_q;
  assign rd_do = rd_en_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (wr_do && !rd_do)      count_d = count_q + CW'(1);
    else if (rd_do && !wr_do) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_do) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_do) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_do && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/feature_concat.sv
// Merges two HWC feature streams per pixel: IN1_CHANNELS words of stream 1, then IN2_CHANNELS of stream 2.
module feature_concat
  import feature_concat_pkg::*;
#(
  parameter int unsigned HEIGHT       = 32,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned IN1_CHANNELS = 512,
  parameter int unsigned IN2_CHANNELS = 512,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] feature_in1,
  input  logic                  feature_valid1,
  input  logic [DATA_WIDTH-1:0] feature_in2,
  input  logic                  feature_valid2,
  output logic [DATA_WIDTH-1:0] feature_out,
  output logic                  feature_valid_out,
  output logic                  concat_done,
  output logic                  overflow
);

  localparam int unsigned W1_TOTAL = frame_words(HEIGHT, WIDTH, IN1_CHANNELS);
  localparam int unsigned W2_TOTAL = frame_words(HEIGHT, WIDTH, IN2_CHANNELS);
  localparam int unsigned NPIX     = HEIGHT * WIDTH;
  localparam int unsigned MAXC     = (IN1_CHANNELS > IN2_CHANNELS) ? IN1_CHANNELS : IN2_CHANNELS;
  localparam int unsigned CNT1_W   = clog2(W1_TOTAL + 1);
  localparam int unsigned CNT2_W   = clog2(W2_TOTAL + 1);
  localparam int unsigned CH_W     = clog2(MAXC + 1);
  localparam int unsigned PIX_W    = clog2(NPIX + 1);

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [CNT1_W-1:0]   cnt1_q, cnt1_d;
  logic [CNT2_W-1:0]   cnt2_q, cnt2_d;
  logic                ovf_q, ovf_d;
  logic                fin_q, fin_d;

  logic                pend_vld_q, pend_last_q, out_last_q;
  phase_t              pend_sel_q;
  logic [DATA_WIDTH-1:0] feature_out_q;
  logic                valid_out_q, done_q;

  logic                run, flush;
  logic                full1, empty1, full2, empty2;
  logic [DATA_WIDTH-1:0] rd1, rd2;
  logic                acc1, acc2, ovf1, ovf2;
  logic                pop, last_ch, last_word;

  assign run   = (state_q == RUN);
  assign flush = (state_q == IDLE) && start;

  // Full-FIFO hits flag overflow even when the frame target is already met.
  assign acc1 = run && feature_valid1 && (cnt1_q < CNT1_W'(W1_TOTAL)) && !full1;
  assign acc2 = run && feature_valid2 && (cnt2_q < CNT2_W'(W2_TOTAL)) && !full2;
  assign ovf1 = run && feature_valid1 && full1;
  assign ovf2 = run && feature_valid2 && full2;

  assign pop       = run && !fin_q && ((phase_q == SEL1) ? !empty1 : !empty2);
  assign last_ch   = (phase_q == SEL1) ? (ch_q == CH_W'(IN1_CHANNELS - 1))
                                       : (ch_q == CH_W'(IN2_CHANNELS - 1));
  assign last_word = pop && (phase_q == SEL2) && last_ch && (pix_q == PIX_W'(NPIX - 1));

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .wr_en_i(acc1), .wr_data_i(feature_in1),
    .rd_en_i(pop && (phase_q == SEL1)), .rd_data_o(rd1),
    .full_o(full1), .empty_o(empty1)
  );

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .wr_en_i(acc2), .wr_data_i(feature_in2),
    .rd_en_i(pop && (phase_q == SEL2)), .rd_data_o(rd2),
    .full_o(full2), .empty_o(empty2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= SEL1;
      ch_q    <= '0;
      pix_q   <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      ovf_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      ovf_q   <= ovf_d;
      fin_q   <= fin_d;
    end
  end

  // Frame control, accept counters and output sequencer.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    ovf_d   = ovf_q;
    fin_d   = fin_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          phase_d = SEL1;
          ch_d    = '0;
          pix_d   = '0;
          cnt1_d  = '0;
          cnt2_d  = '0;
          ovf_d   = 1'b0;
          fin_d   = 1'b0;
        end
      end
      RUN: begin
        if (acc1) cnt1_d = cnt1_q + CNT1_W'(1);
        if (acc2) cnt2_d = cnt2_q + CNT2_W'(1);
        if (ovf1 || ovf2) ovf_d = 1'b1;
        if (pop) begin
          if (!last_ch) begin
            ch_d = ch_q + CH_W'(1);
          end else begin
            ch_d = '0;
            if (phase_q == SEL1) begin
              phase_d = SEL2;
            end else begin
              phase_d = SEL1;
              pix_d   = pix_q + PIX_W'(1);
              if (pix_q == PIX_W'(NPIX - 1)) fin_d = 1'b1;
            end
          end
        end
        if (out_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop -> registered FIFO read -> output register; done follows the final valid word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q    <= 1'b0;
      pend_sel_q    <= SEL1;
      pend_last_q   <= 1'b0;
      out_last_q    <= 1'b0;
      feature_out_q <= '0;
      valid_out_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      pend_vld_q  <= pop;
      pend_sel_q  <= phase_q;
      pend_last_q <= last_word;
      out_last_q  <= pend_last_q;
      valid_out_q <= pend_vld_q;
      done_q      <= out_last_q;
      if (pend_vld_q) feature_out_q <= (pend_sel_q == SEL1) ? rd1 : rd2;
    end
  end

  assign feature_out       = feature_out_q;
  assign feature_valid_out = valid_out_q;
  assign concat_done       = done_q;
  assign overflow          = ovf_q;

endmodule

// File: tb/tb_feature_concat.sv
// Directed and randomized bench for feature_concat with a per-pixel concatenation reference model.
module tb_feature_concat;

  localparam int unsigned DW = 16;
  localparam int N1 = 12;
  localparam int N2 = 8;
  localparam int NOUT = N1 + N2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] in1 = '0, in2 = '0;
  logic          v1 = 1'b0, v2 = 1'b0;
  logic [DW-1:0] fout;
  logic          fvo, done, ovf;

  feature_concat #(
    .HEIGHT(2), .WIDTH(2), .IN1_CHANNELS(3), .IN2_CHANNELS(2),
    .DATA_WIDTH(DW), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .feature_in1(in1), .feature_valid1(v1),
    .feature_in2(in2), .feature_valid2(v2),
    .feature_out(fout), .feature_valid_out(fvo),
    .concat_done(done), .overflow(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] got[$];
  int            got_cyc[$];
  int            done_total = 0;
  int            done_cyc = 0;
  int            done_with_valid = 0;

  always @(negedge clk) begin
    if (fvo) begin
      got.push_back(fout);
      got_cyc.push_back(cyc);
    end
    if (done) begin
      done_total = done_total + 1;
      done_cyc = cyc;
      if (fvo) done_with_valid = done_with_valid + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] s1[N1];
  logic [DW-1:0] s2[N2];

  // Modes: 0 basic (+start in RUN), 1 skewed, 2 stall, 3 random, 4 excess, 5 overflow.
  task automatic run_frame(input int mode, input string name);
    logic [DW-1:0] exp_q[$];
    int base, d0, dv0, sent1, sent2, drive_cyc, span, last;
    bit w1, w2, finished;
    base = got.size();
    d0 = done_total;
    dv0 = done_with_valid;
    sent1 = 0;
    sent2 = 0;
    drive_cyc = 0;
    finished = 0;
    for (int i = 0; i < N1; i++) s1[i] = (mode == 3) ? DW'($urandom) : DW'(32'h100 + i);
    for (int i = 0; i < N2; i++) s2[i] = (mode == 3) ? DW'($urandom) : DW'(32'h200 + i);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 3; c++) exp_q.push_back(s1[3*p + c]);
      for (int c = 0; c < 2; c++) exp_q.push_back(s2[2*p + c]);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      if (done_total > d0) begin
        finished = 1;
        break;
      end
      start = (mode == 0 && k == 6);
      case (mode)
        1: begin w2 = sent2 < N2; w1 = (sent2 == N2) && (sent1 < N1); end
        2: begin w2 = sent2 < N2; w1 = (sent1 < N1) && !(k >= 4 && k < 9); end
        3: begin
          w2 = (sent2 < N2) && ($urandom_range(3) != 0);
          w1 = (sent1 < N1) && (sent1 < 3 * (sent2 / 2) + 6) && ($urandom_range(1) != 0);
        end
        4: begin w1 = sent1 < N1; w2 = sent2 < N2 + 4; end
        5: begin w2 = sent2 < N2 + 1; w1 = (sent2 > N2) && (sent1 < N1); end
        default: begin w1 = sent1 < N1; w2 = sent2 < N2; end
      endcase
      v1 = w1;
      v2 = w2;
      in1 = w1 ? s1[sent1] : 16'hdead;
      in2 = !w2 ? 16'hbeef : (sent2 < N2) ? s2[sent2] : DW'(32'h208 + sent2 - N2);
      if (w1 && sent1 == 0) drive_cyc = cyc;
      if (w1) sent1++;
      if (w2) sent2++;
      @(negedge clk);
    end
    start = 1'b0;
    v1 = 1'b0;
    v2 = 1'b0;
    check({name, "_done_seen"}, 32'(finished), 32'd1);
    repeat (4) @(negedge clk);
    check({name, "_count"}, 32'(got.size() - base), 32'(NOUT));
    for (int i = 0; i < NOUT; i++) begin
      if (base + i < got.size())
        check($sformatf("%s_word%0d", name, i), 32'(got[base + i]), 32'(exp_q[i]));
    end
    check({name, "_done_pulses"}, 32'(done_total - d0), 32'd1);
    check({name, "_done_vs_valid"}, 32'(done_with_valid - dv0), 32'd0);
    if (got.size() > base) begin
      last = got.size() - 1;
      check({name, "_done_timing"}, 32'(done_cyc), 32'(got_cyc[last] + 1));
      check({name, "_hold"}, 32'(fout), 32'(exp_q[NOUT - 1]));
      check({name, "_valid_low"}, 32'(fvo), 32'd0);
      span = got_cyc[last] - got_cyc[base];
      if (mode == 1) check({name, "_latency"}, 32'(got_cyc[base]), 32'(drive_cyc + 3));
      if (mode == 2) check({name, "_stall_gap"}, 32'(span > NOUT - 1), 32'd1);
    end
    check({name, "_overflow"}, 32'(ovf), 32'(mode == 5));
  endtask

  initial begin
    int base, d0;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(fout), 32'd0);
    check("rst_valid", 32'(fvo), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Valids while idle must not reach the output.
    base = got.size();
    d0 = done_total;
    for (int i = 0; i < 10; i++) begin
      v1 = 1'b1; v2 = 1'b1;
      in1 = DW'(32'h300 + i); in2 = DW'(32'h400 + i);
      @(negedge clk);
    end
    v1 = 1'b0; v2 = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_no_output", 32'(got.size() - base), 32'd0);
    check("idle_no_done", 32'(done_total - d0), 32'd0);

    run_frame(0, "basic");
    run_frame(1, "skew");
    run_frame(2, "stall");
    run_frame(5, "overflow");
    run_frame(4, "excess");

    // Abort a frame with an asynchronous reset part way through.
    for (int i = 0; i < N1; i++) s1[i] = DW'(32'h100 + i);
    for (int i = 0; i < N2; i++) s2[i] = DW'(32'h200 + i);
    d0 = done_total;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1; v2 = 1'b1;
      in1 = s1[i]; in2 = s2[i];
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_out", 32'(fout), 32'd0);
    check("abort_valid", 32'(fvo), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    v1 = 1'b0; v2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'(done_total - d0), 32'd0);
    run_frame(0, "after_abort");

    for (int r = 0; r < 3; r++) run_frame(3, $sformatf("rand%0d", r));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
